// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the shared-ALU arbiter: two request channels
// (valid/ready plus operands) and two response channels (valid/ready plus
// a shared result/zero bus).
interface alu_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4
);
  logic [1:0]                  req_valid;
  logic [1:0]                  req_ready;
  logic [2*DATA_WIDTH-1:0]     req_srca;
  logic [2*DATA_WIDTH-1:0]     req_srcb;
  logic [2*ALU_CTRL_WIDTH-1:0] req_ctrl;
  logic [2*DATA_WIDTH-1:0]     req_pc;

  logic [1:0]                  rsp_valid;
  logic [1:0]                  rsp_ready;
  logic [DATA_WIDTH-1:0]       rsp_result;
  logic                        rsp_zero;

  // Requester side: presents operations, consumes results.
  modport master (
    output req_valid, req_srca, req_srcb, req_ctrl, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  // Arbiter side: accepts operations, returns results.
  modport slave (
    input  req_valid, req_srca, req_srcb, req_ctrl, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between two requesters. Round-robin pick in
// IDLE, one EXEC cycle with the registered operands on the ALU, then a
// held response in RESP until the owning requester takes it.
module alu_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_arbiter_if.slave              bus,
  output logic [DATA_WIDTH-1:0]     alu_srca,
  output logic [DATA_WIDTH-1:0]     alu_srcb,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output logic [DATA_WIDTH-1:0]     alu_pc,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     srca;
    logic [DATA_WIDTH-1:0]     srcb;
    logic [ALU_CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0]     pc;
  } op_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
  } res_t;

  state_e     state_q;
  logic       gnt_q;        // owner of the operation in flight
  logic       last_gnt_q;   // most recent winner, drives round-robin
  op_t        op_q;
  res_t       res_q;
  logic [1:0] rsp_valid_q;

  logic       win_d;        // index of the requester that would win now
  logic [1:0] grant_d;      // one-hot accept strobe (req_ready)
  op_t        op_d;         // winner's operand slices
  logic       rsp_fire;

  // Round-robin winner selection and the combinational accept strobe.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    win_d   = 1'b0;
    grant_d = 2'b00;
    case (bus.req_valid)
      2'b01:   win_d = 1'b0;
      2'b10:   win_d = 1'b1;
      2'b11:   win_d = ~last_gnt_q;
      default: win_d = 1'b0;
    endcase
    // Reset also masks the strobe so nothing looks accepted while held in reset.
    if ((state_q == IDLE) && rst_n && (bus.req_valid != 2'b00)) begin
      grant_d = win_d ? 2'b10 : 2'b01;
    end
  end

  // Winner's operand slices, forwarded without modification.
  always_comb begin
    op_d.srca = bus.req_srca[int'(win_d)*DATA_WIDTH +: DATA_WIDTH];
    op_d.srcb = bus.req_srcb[int'(win_d)*DATA_WIDTH +: DATA_WIDTH];
    op_d.ctrl = bus.req_ctrl[int'(win_d)*ALU_CTRL_WIDTH +: ALU_CTRL_WIDTH];
    op_d.pc   = bus.req_pc[int'(win_d)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rsp_fire = (state_q == RESP) && bus.rsp_ready[gnt_q];

  // Arbiter FSM: state, ownership, operand and result registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled on the edge) and all state uses <= so every register updates together.
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;   // makes requester 0 win the first tie
      op_q        <= '0;
      res_q       <= '0;
      rsp_valid_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d != 2'b00) begin
            op_q       <= op_d;
            gnt_q      <= win_d;
            last_gnt_q <= win_d;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          res_q.result <= alu_result;
          res_q.zero   <= alu_zero;
          rsp_valid_q  <= gnt_q ? 2'b10 : 2'b01;
          state_q      <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the response; the other bit is ignored.
          if (rsp_fire) begin
            rsp_valid_q <= 2'b00;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = grant_d;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q.result;
  assign bus.rsp_zero   = res_q.zero;

  // The ALU always sees the operand register, whatever the state.
  assign alu_srca = op_q.srca;
  assign alu_srcb = op_q.srcb;
  assign alu_ctrl = op_q.ctrl;
  assign alu_pc   = op_q.pc;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU, a transaction-level model checked
// against the DUT every cycle, directed scenarios with literal expectations,
// then randomized traffic.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(CW)) bus ();

  logic [DW-1:0] alu_srca, alu_srcb, alu_pc, alu_result;
  logic [CW-1:0] alu_ctrl;
  logic          alu_zero;
  logic [DW:0]   alu_bus;

  alu_arbiter #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_ctrl   (alu_ctrl),
    .alu_pc     (alu_pc),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  // Reference ALU: returns {zero, result}.
  function automatic logic [DW:0] alu_ref(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] pc);
    logic [DW-1:0] r;
    case (c)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1010: r = pc + (b << 12);
      default: r = a + b;
    endcase
    return {(r == '0), r};
  endfunction

  assign alu_bus    = alu_ref(alu_ctrl, alu_srca, alu_srcb, alu_pc);
  assign alu_result = alu_bus[DW-1:0];
  assign alu_zero   = alu_bus[DW];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit            m_busy  = 1'b0;
  bit            m_own   = 1'b0;
  int            m_age   = 0;     // cycles since accept (1 = ALU cycle)
  bit            m_last  = 1'b1;
  logic [DW-1:0] m_a = '0, m_b = '0, m_pc = '0, m_res = '0;
  logic [CW-1:0] m_c = '0;
  logic          m_zero = 1'b0;

  initial begin : compare
    logic [1:0] exp_rr, exp_rv, v;
    logic [DW:0] zr;
    bit w;
    @(posedge clk);
    forever begin
      @(negedge clk);
      v      = bus.req_valid;
      exp_rr = 2'b00;
      if (rst_n && !m_busy) exp_rr = (v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : v;
      exp_rv = (m_busy && m_age >= 2) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      check("model req_ready",  64'(bus.req_ready),  64'(exp_rr));
      check("model rsp_valid",  64'(bus.rsp_valid),  64'(exp_rv));
      check("model rsp_result", 64'(bus.rsp_result), 64'(m_res));
      check("model rsp_zero",   64'(bus.rsp_zero),   64'(m_zero));
      check("model alu_srca",   64'(alu_srca),       64'(m_a));
      check("model alu_srcb",   64'(alu_srcb),       64'(m_b));
      check("model alu_ctrl",   64'(alu_ctrl),       64'(m_c));
      check("model alu_pc",     64'(alu_pc),         64'(m_pc));
      // advance to what holds after the coming edge
      if (!rst_n) begin
        m_busy = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_c = '0; m_pc = '0;
        m_res = '0; m_zero = 1'b0;
      end else if (m_busy) begin
        if (m_age == 1) begin
          zr = alu_ref(m_c, m_a, m_b, m_pc);
          m_res = zr[DW-1:0]; m_zero = zr[DW]; m_age = 2;
        end else if (bus.rsp_ready[m_own]) begin
          m_busy = 1'b0;
        end
      end else if ((exp_rr & v) != 2'b00) begin
        w      = exp_rr[1];
        m_a    = bus.req_srca[int'(w)*DW +: DW];
        m_b    = bus.req_srcb[int'(w)*DW +: DW];
        m_c    = bus.req_ctrl[int'(w)*CW +: CW];
        m_pc   = bus.req_pc[int'(w)*DW +: DW];
        m_own  = w; m_last = w; m_busy = 1'b1; m_age = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] c, input logic [DW-1:0] pc);
    bus.req_srca[i*DW +: DW] = a;
    bus.req_srcb[i*DW +: DW] = b;
    bus.req_ctrl[i*CW +: CW] = c;
    bus.req_pc[i*DW +: DW]   = pc;
    bus.req_valid[i]         = 1'b1;
  endtask

  // Waits (bounded) for a response and checks it; returns after the handshake edge.
  task automatic wait_rsp(input string nm, input logic [1:0] ev, input logic [DW-1:0] er,
                          input logic ez);
    bit got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        got = 1'b1;
        check({nm, " rsp_valid"},  64'(bus.rsp_valid),  64'(ev));
        check({nm, " rsp_result"}, 64'(bus.rsp_result), 64'(er));
        check({nm, " rsp_zero"},   64'(bus.rsp_zero),   64'(ez));
      end
      tick();
    end
    check({nm, " response seen"}, 64'(got), 64'(1));
  endtask

  logic [CW-1:0] ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1010};

  initial begin : main
    logic [1:0] acc;
    logic [DW-1:0] a;
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_srca  = '0; bus.req_srcb = '0; bus.req_ctrl = '0; bus.req_pc = '0;
    bus.rsp_ready = 2'b11;

    // 1: reset with both requesters asserting
    tick(); tick();
    @(negedge clk);
    check("t1 req_ready",  64'(bus.req_ready),  64'(0));
    check("t1 rsp_valid",  64'(bus.rsp_valid),  64'(0));
    check("t1 alu_srca",   64'(alu_srca),       64'(0));
    check("t1 rsp_result", 64'(bus.rsp_result), 64'(0));
    tick();
    rst_n = 1'b1; bus.req_valid = 2'b00;
    tick();

    // 2: single ADD from requester 0
    set_req(0, 32'd5, 32'd7, 4'b0000, 32'd0);
    @(negedge clk);
    check("t2 req_ready", 64'(bus.req_ready), 64'(2'b01));
    tick(); bus.req_valid = 2'b00;
    @(negedge clk);
    check("t2 alu_srca", 64'(alu_srca), 64'(5));
    tick();
    @(negedge clk);
    check("t2 rsp_valid",  64'(bus.rsp_valid),  64'(2'b01));
    check("t2 rsp_result", 64'(bus.rsp_result), 64'(12));
    check("t2 rsp_zero",   64'(bus.rsp_zero),   64'(0));
    tick();

    // 3: contention after a fresh reset; requester 0 re-requests at once
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_req(0, 32'd9, 32'd9, 4'b0001, 32'd0);
    set_req(1, 32'd3, 32'd1, 4'b0001, 32'd0);
    @(negedge clk);
    check("t3 first grant", 64'(bus.req_ready), 64'(2'b01));
    tick();
    set_req(0, 32'd4, 32'd4, 4'b0000, 32'd0);
    wait_rsp("t3 req0", 2'b01, 32'd0, 1'b1);
    @(negedge clk);
    check("t3 rr grant", 64'(bus.req_ready), 64'(2'b10));
    tick(); bus.req_valid[1] = 1'b0;
    wait_rsp("t3 req1", 2'b10, 32'd2, 1'b0);
    @(negedge clk);
    check("t3 third grant", 64'(bus.req_ready), 64'(2'b01));
    tick(); bus.req_valid[0] = 1'b0;
    wait_rsp("t3 req0b", 2'b01, 32'd8, 1'b0);

    // 4: response backpressure while requester 1 waits
    set_req(0, 32'd1, 32'd2, 4'b0000, 32'd0);
    @(negedge clk);
    check("t4 grant", 64'(bus.req_ready), 64'(2'b01));
    tick();
    bus.req_valid[0] = 1'b0;
    set_req(1, 32'd10, 32'd20, 4'b0000, 32'd0);
    bus.rsp_ready = 2'b10;
    @(negedge clk); tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4 held rsp_valid",  64'(bus.rsp_valid),  64'(2'b01));
      check("t4 held rsp_result", 64'(bus.rsp_result), 64'(3));
      check("t4 held req_ready",  64'(bus.req_ready),  64'(0));
      tick();
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    check("t4 hs req_ready", 64'(bus.req_ready), 64'(0));
    tick();
    @(negedge clk);
    check("t4 next grant", 64'(bus.req_ready), 64'(2'b10));
    tick();
    bus.req_valid[1] = 1'b0; bus.rsp_ready = 2'b11;
    wait_rsp("t4 req1", 2'b10, 32'd30, 1'b0);

    // 5: reset while the ALU cycle is under way
    set_req(0, 32'd1, 32'd1, 4'b0000, 32'd0);
    set_req(1, 32'd2, 32'd2, 4'b0000, 32'd0);
    @(negedge clk);
    check("t5 grant", 64'(bus.req_ready), 64'(2'b01));
    tick();
    rst_n = 1'b0; bus.req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5 no rsp", 64'(bus.rsp_valid), 64'(0));
      tick();
    end
    set_req(0, 32'd6, 32'd1, 4'b0001, 32'd0);
    set_req(1, 32'd2, 32'd2, 4'b0000, 32'd0);
    @(negedge clk);
    check("t5 grant after reset", 64'(bus.req_ready), 64'(2'b01));
    tick(); bus.req_valid = 2'b00;
    wait_rsp("t5 req0", 2'b01, 32'd5, 1'b0);

    // 6: AUIPC-style op from requester 1, PC and control forwarded verbatim
    set_req(1, 32'h55, 32'h1, 4'b1010, 32'h100);
    @(negedge clk);
    check("t6 grant", 64'(bus.req_ready), 64'(2'b10));
    tick(); bus.req_valid = 2'b00;
    @(negedge clk);
    check("t6 alu_pc",   64'(alu_pc),   64'(32'h100));
    check("t6 alu_ctrl", 64'(alu_ctrl), 64'(4'b1010));
    tick();
    wait_rsp("t6 auipc", 2'b10, 32'h1100, 1'b0);

    // randomized traffic, with occasional resets and withdrawn requests
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      tick();
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || (bus.req_valid[i] && $urandom_range(0, 15) == 0)) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          a = $urandom;
          set_req(i, a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
                  ops[$urandom_range(0, 6)], $urandom);
        end
      end
      bus.rsp_ready = 2'($urandom);
    end
    rst_n = 1'b1; bus.req_valid = 2'b00; bus.rsp_ready = 2'b11;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
